// File: rtl/ika9958_cpuif_if.sv
// CPU-side bus, register/palette write ports and VRAM request channel of the VDP CPU interface.
// slave is the interface block itself; master is the surrounding environment.
interface ika9958_cpuif_if;
  logic        i_CSW_n;
  logic        i_CSR_n;
  logic [1:0]  i_MODE;
  logic [7:0]  i_CD;
  logic [7:0]  o_CD;
  logic        o_CD_OE;
  logic        o_REG_WR;
  logic [5:0]  o_REG_ADDR;
  logic [7:0]  o_REG_DATA;
  logic        o_PAL_WR;
  logic [3:0]  o_PAL_ADDR;
  logic [8:0]  o_PAL_DATA;
  logic [3:0]  o_STATUS_SEL;
  logic [7:0]  i_STATUS_DATA;
  logic        o_STATUS_RD;
  logic        o_VRAM_REQ;
  logic        o_VRAM_WE;
  logic [16:0] o_VRAM_ADDR;
  logic [7:0]  o_VRAM_WDATA;
  logic        i_VRAM_ACK;
  logic [7:0]  i_VRAM_RDATA;

  modport slave (
    input  i_CSW_n, i_CSR_n, i_MODE, i_CD, i_STATUS_DATA, i_VRAM_ACK, i_VRAM_RDATA,
    output o_CD, o_CD_OE, o_REG_WR, o_REG_ADDR, o_REG_DATA, o_PAL_WR, o_PAL_ADDR, o_PAL_DATA,
           o_STATUS_SEL, o_STATUS_RD, o_VRAM_REQ, o_VRAM_WE, o_VRAM_ADDR, o_VRAM_WDATA
  );

  modport master (
    output i_CSW_n, i_CSR_n, i_MODE, i_CD, i_STATUS_DATA, i_VRAM_ACK, i_VRAM_RDATA,
    input  o_CD, o_CD_OE, o_REG_WR, o_REG_ADDR, o_REG_DATA, o_PAL_WR, o_PAL_ADDR, o_PAL_DATA,
           o_STATUS_SEL, o_STATUS_RD, o_VRAM_REQ, o_VRAM_WE, o_VRAM_ADDR, o_VRAM_WDATA
  );
endinterface

// File: rtl/ika9958_cpuif.sv
// VDP CPU port decoder: strobe sync, two-byte register/address/palette sequences,
// indirect register port and the VRAM access pointer with its request channel.
module ika9958_cpuif #(
  parameter int unsigned NREG = 47
) (
  input logic            i_XTAL1,
  input logic            i_RST,
  input logic            i_CEN,
  ika9958_cpuif_if.slave bus
);

  localparam logic [6:0] NregLim = 7'(NREG);

  typedef struct packed {
    logic        csw_s1;
    logic        csw_s2;
    logic        csw_e;
    logic        csr_s1;
    logic        csr_s2;
    logic        csr_e;
    logic        rd_kill;
    logic [1:0]  rd_mode;
    logic        p1_flag;
    logic [7:0]  p1_latch;
    logic        pal_flag;
    logic [5:0]  pal_latch;
    logic [2:0]  r14;
    logic [3:0]  r15;
    logic [7:0]  r16;
    logic [7:0]  r17;
    logic [16:0] ptr;
    logic [7:0]  rd_latch;
    logic        req;
    logic        we;
    logic [16:0] vaddr;
    logic [7:0]  wdata;
    logic        reg_wr;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        pal_wr;
    logic [3:0]  pal_addr;
    logic [8:0]  pal_data;
    logic        status_rd;
  } state_t;

  state_t st_q, st_d;

  logic       wr_ev, rd_ev, csr_fall, csr_rise;
  logic       rw_en;
  logic [5:0] rw_num;
  logic [7:0] rw_data;
  logic [7:0] cd_mux;

  assign wr_ev    = st_q.csw_e & ~st_q.csw_s2;
  assign csr_fall = st_q.csr_e & ~st_q.csr_s2;
  assign csr_rise = ~st_q.csr_e & st_q.csr_s2;
  assign rd_ev    = csr_rise & ~st_q.rd_kill;

  always_ff @(posedge i_XTAL1) begin
    if (i_RST) begin
      st_q        <= '0;
      st_q.csw_s1 <= 1'b1;
      st_q.csw_s2 <= 1'b1;
      st_q.csw_e  <= 1'b1;
      st_q.csr_s1 <= 1'b1;
      st_q.csr_s2 <= 1'b1;
      st_q.csr_e  <= 1'b1;
    end else if (i_CEN) begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d           = st_q;
    st_d.csw_s1    = bus.i_CSW_n;
    st_d.csw_s2    = st_q.csw_s1;
    st_d.csw_e     = st_q.csw_s2;
    st_d.csr_s1    = bus.i_CSR_n;
    st_d.csr_s2    = st_q.csr_s1;
    st_d.csr_e     = st_q.csr_s2;
    st_d.reg_wr    = 1'b0;
    st_d.pal_wr    = 1'b0;
    st_d.status_rd = 1'b0;
    rw_en          = 1'b0;
    rw_num         = '0;
    rw_data        = '0;

    if (csr_fall) st_d.rd_mode = bus.i_MODE;
    // A read overlapping a write strobe is dropped when its rising edge arrives.
    if (!st_q.csw_s2 && !st_q.csr_s2) st_d.rd_kill = 1'b1;
    else if (csr_rise)                st_d.rd_kill = 1'b0;

    if (st_q.req && bus.i_VRAM_ACK) begin
      st_d.req = 1'b0;
      st_d.ptr = st_q.ptr + 17'd1;
      if (!st_q.we) st_d.rd_latch = bus.i_VRAM_RDATA;
    end

    if (wr_ev) begin
      unique case (bus.i_MODE)
        2'd0: begin
          if (!st_q.req) begin
            st_d.p1_flag = 1'b0;
            st_d.req     = 1'b1;
            st_d.we      = 1'b1;
            st_d.vaddr   = st_q.ptr;
            st_d.wdata   = bus.i_CD;
          end
        end
        2'd1: begin
          if (!st_q.p1_flag) begin
            st_d.p1_flag  = 1'b1;
            st_d.p1_latch = bus.i_CD;
          end else begin
            st_d.p1_flag = 1'b0;
            if (bus.i_CD[7]) begin
              rw_en   = 1'b1;
              rw_num  = bus.i_CD[5:0];
              rw_data = st_q.p1_latch;
            end else begin
              st_d.ptr = {st_q.r14, bus.i_CD[5:0], st_q.p1_latch};
              if (!bus.i_CD[6] && !st_q.req) begin
                st_d.req   = 1'b1;
                st_d.we    = 1'b0;
                st_d.vaddr = {st_q.r14, bus.i_CD[5:0], st_q.p1_latch};
              end
            end
          end
        end
        2'd2: begin
          if (!st_q.pal_flag) begin
            st_d.pal_flag  = 1'b1;
            st_d.pal_latch = {bus.i_CD[6:4], bus.i_CD[2:0]};
          end else begin
            st_d.pal_flag = 1'b0;
            st_d.pal_wr   = 1'b1;
            st_d.pal_addr = st_q.r16[3:0];
            st_d.pal_data = {bus.i_CD[2:0], st_q.pal_latch};
            st_d.r16      = {st_q.r16[7:4], st_q.r16[3:0] + 4'd1};
          end
        end
        2'd3: begin
          if (st_q.r17[5:0] != 6'd17) begin
            rw_en   = 1'b1;
            rw_num  = st_q.r17[5:0];
            rw_data = bus.i_CD;
          end
          if (!st_q.r17[7]) st_d.r17[5:0] = st_q.r17[5:0] + 6'd1;
        end
      endcase
    end else if (rd_ev) begin
      case (st_q.rd_mode)
        2'd0: begin
          if (!st_q.req) begin
            st_d.p1_flag = 1'b0;
            st_d.req     = 1'b1;
            st_d.we      = 1'b0;
            st_d.vaddr   = st_q.ptr;
          end
        end
        2'd1: begin
          st_d.p1_flag   = 1'b0;
          st_d.status_rd = 1'b1;
        end
        default: ;
      endcase
    end

    // Shared register write path for port 1 and the indirect port 3.
    if (rw_en) begin
      if ({1'b0, rw_num} < NregLim) begin
        st_d.reg_wr   = 1'b1;
        st_d.reg_addr = rw_num;
        st_d.reg_data = rw_data;
      end
      case (rw_num)
        6'd14: st_d.r14 = rw_data[2:0];
        6'd15: st_d.r15 = rw_data[3:0];
        6'd16: begin
          st_d.r16      = rw_data;
          st_d.pal_flag = 1'b0;
        end
        6'd17: st_d.r17 = rw_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    cd_mux = 8'hFF;
    case (bus.i_MODE)
      2'd0:    cd_mux = st_q.rd_latch;
      2'd1:    cd_mux = bus.i_STATUS_DATA;
      default: cd_mux = 8'hFF;
    endcase
  end

  assign bus.o_CD_OE      = ~bus.i_CSR_n;
  assign bus.o_CD         = bus.i_CSR_n ? 8'h00 : cd_mux;
  assign bus.o_REG_WR     = st_q.reg_wr;
  assign bus.o_REG_ADDR   = st_q.reg_addr;
  assign bus.o_REG_DATA   = st_q.reg_data;
  assign bus.o_PAL_WR     = st_q.pal_wr;
  assign bus.o_PAL_ADDR   = st_q.pal_addr;
  assign bus.o_PAL_DATA   = st_q.pal_data;
  assign bus.o_STATUS_SEL = st_q.r15;
  assign bus.o_STATUS_RD  = st_q.status_rd;
  assign bus.o_VRAM_REQ   = st_q.req;
  assign bus.o_VRAM_WE    = st_q.we;
  assign bus.o_VRAM_ADDR  = st_q.vaddr;
  assign bus.o_VRAM_WDATA = st_q.wdata;

endmodule

// File: tb/tb_ika9958_cpuif.sv
// Scoreboard bench for ika9958_cpuif: a behavioural port model queues expected strobes and
// VRAM requests; a monitor pops and compares them as the DUT emits them.
module tb_ika9958_cpuif;

  localparam int NREG  = 47;
  localparam int KReg  = 1;
  localparam int KPal  = 2;
  localparam int KStat = 3;
  localparam int KVwr  = 4;
  localparam int KVrd  = 5;

  typedef struct {
    int kind;
    int a;
    int d;
  } exp_t;

  logic clk, rst, cen;
  ika9958_cpuif_if bif ();

  ika9958_cpuif #(.NREG(NREG)) dut (
    .i_XTAL1 (clk),
    .i_RST   (rst),
    .i_CEN   (cen),
    .bus     (bif.slave)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t expq[$];
  logic ack_hold = 1'b0;

  // Behavioural model state
  int m_f1, m_l1, m_pf, m_l2, m_r14, m_r15, m_r16, m_r17, m_ptr, m_rd, m_pend, m_pend_rd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int a, input int d);
    exp_t e;
    e.kind = k; e.a = a; e.d = d;
    expq.push_back(e);
  endtask

  task automatic model_reset();
    m_f1 = 0; m_l1 = 0; m_pf = 0; m_l2 = 0;
    m_r14 = 0; m_r15 = 0; m_r16 = 0; m_r17 = 0;
    m_ptr = 0; m_rd = 0; m_pend = 0; m_pend_rd = 0;
    expq.delete();
  endtask

  task automatic mdl_regwrite(input int n, input int d);
    if (n < NREG) push(KReg, n, d);
    case (n)
      14: m_r14 = d;
      15: m_r15 = d;
      16: begin m_r16 = d; m_pf = 0; end
      17: m_r17 = d;
      default: ;
    endcase
  endtask

  task automatic model_write(input int m, input int d);
    int t;
    case (m)
      0: if (m_pend == 0) begin
        m_f1 = 0; push(KVwr, m_ptr, d); m_pend = 1; m_pend_rd = 0;
      end
      1: if (m_f1 == 0) begin
        m_l1 = d; m_f1 = 1;
      end else begin
        m_f1 = 0;
        if ((d & 128) != 0) mdl_regwrite(d % 64, m_l1);
        else begin
          m_ptr = (m_r14 % 8) * 16384 + (d % 64) * 256 + m_l1;
          if ((d & 64) == 0 && m_pend == 0) begin
            push(KVrd, m_ptr, 0); m_pend = 1; m_pend_rd = 1;
          end
        end
      end
      2: if (m_pf == 0) begin
        m_l2 = d; m_pf = 1;
      end else begin
        push(KPal, m_r16 % 16, (d % 8) * 64 + ((m_l2 / 16) % 8) * 8 + m_l2 % 8);
        m_r16 = (m_r16 / 16) * 16 + (m_r16 + 1) % 16;
        m_pf = 0;
      end
      default: begin
        t = m_r17 % 64;
        if (t != 17) mdl_regwrite(t, d);
        if ((m_r17 & 128) == 0) m_r17 = (m_r17 / 64) * 64 + (t + 1) % 64;
      end
    endcase
  endtask

  task automatic model_read(input int m);
    if (m == 0 && m_pend == 0) begin
      m_f1 = 0; push(KVrd, m_ptr, 0); m_pend = 1; m_pend_rd = 1;
    end else if (m == 1) begin
      m_f1 = 0; push(KStat, 0, 0);
    end
  endtask

  task automatic bus_write(input int m, input int d);
    model_write(m, d);
    @(posedge clk); #1;
    bif.i_MODE = 2'(m); bif.i_CD = 8'(d); bif.i_CSW_n = 1'b0;
    repeat (4) @(posedge clk); #1;
    bif.i_CSW_n = 1'b1;
    repeat (4) @(posedge clk); #1;
  endtask

  // Write strobe with the read strobe held low over it; only the write may take effect.
  task automatic bus_write_rd(input int m, input int d);
    model_write(m, d);
    @(posedge clk); #1;
    bif.i_MODE = 2'(m); bif.i_CD = 8'(d); bif.i_CSW_n = 1'b0; bif.i_CSR_n = 1'b0;
    repeat (4) @(posedge clk); #1;
    bif.i_CSW_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    bif.i_CSR_n = 1'b1;
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic bus_read(input int m);
    logic [7:0] st, exp_cd;
    st = 8'($urandom);
    @(posedge clk); #1;
    bif.i_MODE = 2'(m); bif.i_STATUS_DATA = st; bif.i_CSR_n = 1'b0;
    #2;
    exp_cd = (m == 0) ? 8'(m_rd) : (m == 1) ? st : 8'hFF;
    check($sformatf("read_cd_port%0d", m), bif.o_CD, exp_cd);
    check("read_cd_oe", bif.o_CD_OE, 1);
    if (m == 1) check("status_sel", bif.o_STATUS_SEL, m_r15 % 16);
    repeat (4) @(posedge clk); #1;
    model_read(m);
    bif.i_CSR_n = 1'b1;
    #1;
    check("cd_idle", {bif.o_CD_OE, bif.o_CD}, 0);
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_pend != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (m_pend != 0) begin
      tests++; fails++;
      $display("FAIL vram_ack_timeout: request still pending after %0d cycles, required ack", n);
      m_pend = 0;
    end
  endtask

  task automatic match(input int k, input int a, input int d);
    exp_t e;
    if (expq.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_output: got kind=%0d addr=0x%0h data=0x%0h, required none", k, a, d);
    end else begin
      e = expq.pop_front();
      check("out_kind", k, e.kind);
      check("out_addr", a, e.a);
      check("out_data", d, e.d);
    end
  endtask

  // Monitor
  initial begin
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bif.o_REG_WR) match(KReg, bif.o_REG_ADDR, bif.o_REG_DATA);
        if (bif.o_PAL_WR) match(KPal, bif.o_PAL_ADDR, bif.o_PAL_DATA);
        if (bif.o_STATUS_RD) match(KStat, 0, 0);
        if (bif.o_VRAM_REQ && !req_prev)
          match(bif.o_VRAM_WE ? KVwr : KVrd, bif.o_VRAM_ADDR,
                bif.o_VRAM_WE ? int'(bif.o_VRAM_WDATA) : 0);
      end
      req_prev = bif.o_VRAM_REQ;
    end
  end

  // VRAM arbiter stand-in with random acceptance latency
  initial begin
    bif.i_VRAM_ACK = 1'b0;
    bif.i_VRAM_RDATA = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && !ack_hold && bif.o_VRAM_REQ && $urandom_range(0, 2) == 0) begin
        bif.i_VRAM_ACK = 1'b1;
        bif.i_VRAM_RDATA = 8'($urandom);
        @(negedge clk);
        bif.i_VRAM_ACK = 1'b0;
        check("req_drop_after_ack", bif.o_VRAM_REQ, 0);
        m_ptr = (m_ptr + 1) % 131072;
        if (m_pend_rd != 0) m_rd = bif.i_VRAM_RDATA;
        m_pend = 0;
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1; cen = 1'b1;
    bif.i_CSW_n = 1'b1; bif.i_CSR_n = 1'b1; bif.i_MODE = 2'd0; bif.i_CD = 8'h00;
    bif.i_STATUS_DATA = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_strobes", {bif.o_REG_WR, bif.o_PAL_WR, bif.o_STATUS_RD, bif.o_VRAM_REQ}, 0);
    check("rst_status_sel", bif.o_STATUS_SEL, 0);
    check("rst_cd", {bif.o_CD_OE, bif.o_CD}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Register write through port 1, then a lone first byte
    bus_write(1, 8'h5A); bus_write(1, 8'h87);
    bus_write(1, 8'h12); bus_write(1, 8'h8F);

    // Address setup without prefetch, then sequential VRAM writes
    bus_write(1, 8'h03); bus_write(1, 8'h8E);
    bus_write(1, 8'h34); bus_write(1, 8'h52);
    bus_write(0, 8'hAA); wait_idle();
    bus_write(0, 8'h55); wait_idle();

    // Pointer wrap and a port-0 write ignored while a request is outstanding
    bus_write(1, 8'h07); bus_write(1, 8'h8E);
    bus_write(1, 8'hFF); bus_write(1, 8'h7F);
    bus_write(0, 8'h11); wait_idle();
    ack_hold = 1'b1;
    bus_write(0, 8'h22);
    bus_write(0, 8'h33);
    check("held_req", bif.o_VRAM_REQ, 1);
    check("held_addr", bif.o_VRAM_ADDR, 17'h00000);
    check("held_wdata", bif.o_VRAM_WDATA, 8'h22);
    ack_hold = 1'b0;
    wait_idle();
    bus_write(0, 8'h44); wait_idle();

    // Palette from index 15, then wrap to 0
    bus_write(1, 8'h0F); bus_write(1, 8'h90);
    bus_write(2, 8'h73); bus_write(2, 8'h05);
    bus_write(2, 8'h01); bus_write(2, 8'h02);

    // Indirect port: auto-increment across NREG, then fixed target 17
    bus_write(1, 8'h2E); bus_write(1, 8'h91);
    for (int i = 0; i < 4; i++) bus_write(3, $urandom_range(0, 255));
    bus_write(1, 8'h91); bus_write(1, 8'h91);
    for (int i = 0; i < 2; i++) bus_write(3, $urandom_range(0, 255));

    // Status read clears the port-1 flag
    bus_write(1, 8'h02); bus_write(1, 8'h8F);
    bus_write(1, 8'h11); bus_read(1);
    bus_write(1, 8'h81); bus_write(1, 8'h85);

    // Overlapping strobes: read must be suppressed
    bus_write_rd(1, 8'h11);
    bus_write(1, 8'h83);

    // Prefetch and port-0 reads, unused ports
    bus_write(1, 8'h00); bus_write(1, 8'h00); wait_idle();
    bus_read(0); wait_idle();
    bus_read(0); wait_idle();
    bus_read(2); bus_read(3);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) bus_write($urandom_range(0, 3), $urandom_range(0, 255));
      else bus_read($urandom_range(0, 3));
      wait_idle();
    end

    // Reset while a request is pending
    ack_hold = 1'b1;
    bus_write(0, 8'h5C);
    check("pending_before_rst", bif.o_VRAM_REQ, 1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_abort_req", bif.o_VRAM_REQ, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    ack_hold = 1'b0;
    bus_write(1, 8'h5A); bus_write(1, 8'h87);
    bus_write(0, 8'h66); wait_idle();

    repeat (5) @(posedge clk);
    check("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
